// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common-data-bus write port of the renaming register
// file among NUM_REQ result producers (ALU, LSB, branch unit, ...).
//
// Each producer hands a result to a private 1-entry holding slot. A scheduler
// picks one valid slot per cycle and drives a registered broadcast that reaches
// the register file, RS and ROB in the same cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global ready; low freezes all state
//   flush                 mispredict flush; discards all pending results
//   req_valid/dest/value/rename   per-producer result, flat slices per index
//   req_ready             producer may hand over a result this cycle (comb)
//   register_update_flag  one-cycle broadcast valid pulse
//   register_commit_dest/value, rename_of_commit_ins   broadcast payload
//   cdb_grant             one-hot source of the current broadcast, 0 when idle
//
// Build option: define CDB_FIXED_PRIORITY_EN for fixed priority (lowest index
// wins, no rotation pointer). Default build is round-robin.

// One holding slot. A take (grant) and a load in the same cycle keep the slot
// valid with the new contents, so a producer can sustain one result per cycle.
module cdb_slot #(
  parameter int TAG_W  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              load,
  input  logic              take,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] value_in,
  input  logic [TAG_W-1:0]  rename_in,
  output logic              v,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] value,
  output logic [TAG_W-1:0]  rename
);
  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= 1'b0;
      dest   <= '0;
      value  <= '0;
      rename <= '0;
    end else if (rdy) begin
      if (flush) begin
        v <= 1'b0;
      end else if (load) begin
        v      <= 1'b1;
        dest   <= dest_in;
        value  <= value_in;
        rename <= rename_in;
      end else if (take) begin
        v <= 1'b0;
      end
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 4,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [REG_W*NUM_REQ-1:0]  req_dest,
  input  logic [DATA_W*NUM_REQ-1:0] req_value,
  input  logic [TAG_W*NUM_REQ-1:0]  req_rename,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      register_update_flag,
  output logic [REG_W-1:0]          register_commit_dest,
  output logic [DATA_W-1:0]         register_commit_value,
  output logic [TAG_W-1:0]          rename_of_commit_ins,
  output logic [NUM_REQ-1:0]        cdb_grant
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             buf_v;
  logic [NUM_REQ-1:0][REG_W-1:0]  buf_dest;
  logic [NUM_REQ-1:0][DATA_W-1:0] buf_value;
  logic [NUM_REQ-1:0][TAG_W-1:0]  buf_rename;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             load;
  logic [PTR_W-1:0]               win_idx;
  logic                           any_v;

`ifndef CDB_FIXED_PRIORITY_EN
  logic [PTR_W-1:0] ptr;
`endif

  // Grant only depends on registered slot state, so req_ready has no path
  // from req_valid.
  assign req_ready = {NUM_REQ{rdy & ~flush}} & (~buf_v | gnt);
  assign load      = req_valid & req_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    cdb_slot #(.TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (flush),
      .load      (load[i]),
      .take      (gnt[i]),
      .dest_in   (req_dest[i*REG_W +: REG_W]),
      .value_in  (req_value[i*DATA_W +: DATA_W]),
      .rename_in (req_rename[i*TAG_W +: TAG_W]),
      .v         (buf_v[i]),
      .dest      (buf_dest[i]),
      .value     (buf_value[i]),
      .rename    (buf_rename[i])
    );
  end

  // First valid slot scanning upward from the start index, with wrap.
  always_comb begin
    int idx;
    idx     = 0;
    any_v   = 1'b0;
    win_idx = '0;
    gnt     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CDB_FIXED_PRIORITY_EN
      idx = k;
`else
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!any_v && buf_v[idx]) begin
        any_v   = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
    if (any_v) gnt[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      register_update_flag  <= 1'b0;
      register_commit_dest  <= '0;
      register_commit_value <= '0;
      rename_of_commit_ins  <= '0;
      cdb_grant             <= '0;
`ifndef CDB_FIXED_PRIORITY_EN
      ptr                   <= '0;
`endif
    end else if (rdy) begin
      if (flush) begin
        // Broadcast already on the bus this cycle completes; next is idle.
        register_update_flag <= 1'b0;
        cdb_grant            <= '0;
`ifndef CDB_FIXED_PRIORITY_EN
        ptr                  <= '0;
`endif
      end else if (any_v) begin
        register_update_flag  <= 1'b1;
        register_commit_dest  <= buf_dest[win_idx];
        register_commit_value <= buf_value[win_idx];
        rename_of_commit_ins  <= buf_rename[win_idx];
        cdb_grant             <= gnt;
`ifndef CDB_FIXED_PRIORITY_EN
        ptr <= (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`endif
      end else begin
        // Payload holds while idle; only the valid pulse and grant drop.
        register_update_flag <= 1'b0;
        cdb_grant            <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst, rdy, flush;
  logic [N-1:0]  req_valid;
  logic [5*N-1:0]  req_dest;
  logic [32*N-1:0] req_value;
  logic [4*N-1:0]  req_rename;
  logic [N-1:0]  req_ready;
  logic          register_update_flag;
  logic [4:0]    register_commit_dest;
  logic [31:0]   register_commit_value;
  logic [3:0]    rename_of_commit_ins;
  logic [N-1:0]  cdb_grant;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one pending result per producer, a scan start index,
  // and the last broadcast seen on the bus.
  bit          mv[N];
  logic [4:0]  md[N];
  logic [31:0] mval[N];
  logic [3:0]  mrn[N];
  int          mptr;
  bit          mflag;
  logic [4:0]  mdst;
  logic [31:0] mvalo;
  logic [3:0]  mrno;
  logic [N-1:0] mgnt;
  bit          minit = 0;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(4), .REG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_valid(req_valid), .req_dest(req_dest), .req_value(req_value),
    .req_rename(req_rename), .req_ready(req_ready),
    .register_update_flag(register_update_flag),
    .register_commit_dest(register_commit_dest),
    .register_commit_value(register_commit_value),
    .rename_of_commit_ins(rename_of_commit_ins),
    .cdb_grant(cdb_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(int i, bit v, logic [4:0] d, logic [31:0] val, logic [3:0] r);
    req_valid[i] = v;
    req_dest[i*5 +: 5] = d;
    req_value[i*32 +: 32] = val;
    req_rename[i*4 +: 4] = r;
  endtask

  // One clock: check combinational ready, advance the model across the edge,
  // then check the registered broadcast. Returns at posedge + 1.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
`ifdef CDB_FIXED_PRIORITY_EN
      idx = k;
`else
      idx = (mptr + k) % N;
`endif
      if (w < 0 && mv[idx]) w = idx;
    end
    for (int i = 0; i < N; i++)
      exp_rdy[i] = rdy && !flush && (!mv[i] || w == i);
    if (minit && !rst) chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
      mptr = 0; mflag = 0; mdst = 0; mvalo = 0; mrno = 0; mgnt = 0;
      minit = 1;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < N; i++) mv[i] = 0;
        mflag = 0; mgnt = 0; mptr = 0;
      end else begin
        if (w >= 0) begin
          mflag = 1; mdst = md[w]; mvalo = mval[w]; mrno = mrn[w];
          mgnt = N'(1) << w; mptr = (w + 1) % N;
        end else begin
          mflag = 0; mgnt = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && exp_rdy[i]) begin
            mv[i] = 1; md[i] = req_dest[i*5 +: 5];
            mval[i] = req_value[i*32 +: 32]; mrn[i] = req_rename[i*4 +: 4];
          end else if (i == w) mv[i] = 0;
        end
      end
    end
    #1;
    if (minit) begin
      chk("flag",   64'(register_update_flag),  64'(mflag));
      chk("dest",   64'(register_commit_dest),  64'(mdst));
      chk("value",  64'(register_commit_value), 64'(mvalo));
      chk("rename", 64'(rename_of_commit_ins),  64'(mrno));
      chk("grant",  64'(cdb_grant),             64'(mgnt));
    end
  endtask

  task automatic idle(int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic flush_pulse();
    req_valid = '0; flush = 1; cycle(); flush = 0;
  endtask

  initial begin
    rst = 1; rdy = 1; flush = 0;
    req_valid = '0; req_dest = '0; req_value = '0; req_rename = '0;

    // 1. Reset with all producers requesting
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i+1), 32'(100+i), 4'(i));
    cycle(); cycle();
    chk("rst_flag",  64'(register_update_flag), 64'(0));
    chk("rst_grant", 64'(cdb_grant), 64'(0));
    chk("rst_value", 64'(register_commit_value), 64'(0));
    rst = 0;
    cycle();
    req_valid = '0;
    cycle();
    chk("first_grant", 64'(cdb_grant), 64'(3'b001));
    chk("first_value", 64'(register_commit_value), 64'(100));
    idle(4);

    // 2. Single result from producer 1
    set_req(1, 1, 5'd5, 32'hDEADBEEF, 4'h3);
    cycle();
    req_valid = '0;
    cycle();
    chk("single_flag",  64'(register_update_flag), 64'(1));
    chk("single_dest",  64'(register_commit_dest), 64'(5));
    chk("single_value", 64'(register_commit_value), 64'hDEADBEEF);
    chk("single_ren",   64'(rename_of_commit_ins), 64'(3));
    chk("single_grant", 64'(cdb_grant), 64'(3'b010));
    cycle();
    chk("single_idle", 64'(register_update_flag), 64'(0));

    // 3. Contention from a zero pointer, then again
    flush_pulse();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) set_req(i, 1, 5'(i), 32'(10*(i+1)), 4'(i));
      cycle();
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
        cycle();
        chk("cont_value", 64'(register_commit_value), 64'(10*(i+1)));
        chk("cont_grant", 64'(cdb_grant), 64'(N'(1) << i));
      end
      cycle();
      chk("cont_idle", 64'(register_update_flag), 64'(0));
    end
`ifdef CDB_FIXED_PRIORITY_EN
    set_req(0, 1, 5'd1, 32'd7, 4'd1);
    set_req(1, 1, 5'd2, 32'd8, 4'd2);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("starve_g1", 64'(cdb_grant[1]), 64'(0));
    end
    idle(4);
`endif

    // 4. Back-to-back stream from producer 0
    for (int v = 1; v <= 4; v++) begin
      set_req(0, 1, 5'd9, 32'(v), 4'(v));
      #1 chk("stream_ready", 64'(req_ready[0]), 64'(1));
      cycle();
      if (v > 1) chk("stream_value", 64'(register_commit_value), 64'(v-1));
    end
    req_valid = '0;
    cycle();
    chk("stream_last", 64'(register_commit_value), 64'(4));
    idle(2);

    // 5. Flush while producer 0 is broadcasting
    flush_pulse();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i), 32'(50+i), 4'(i));
    cycle();
    req_valid = '0;
    cycle();
    chk("fl_seen", 64'(register_commit_value), 64'(50));
    flush = 1; set_req(1, 1, 5'd3, 32'd77, 4'd3);
    cycle();
    flush = 0; req_valid = '0;
    chk("fl_idle", 64'(register_update_flag), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_none", 64'(register_update_flag), 64'(0));
    end
    set_req(1, 1, 5'd1, 32'd61, 4'd1);
    set_req(2, 1, 5'd2, 32'd62, 4'd2);
    cycle();
    req_valid = '0;
    cycle();
    chk("fl_ptr0", 64'(cdb_grant), 64'(3'b010));
    idle(3);

    // 6. Freeze with two results pending and the flag high
    flush_pulse();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i), 32'(200+i), 4'(i));
    cycle();
    req_valid = '0;
    cycle();
    rdy = 0; req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("frz_flag",  64'(register_update_flag), 64'(1));
      chk("frz_value", 64'(register_commit_value), 64'(200));
      chk("frz_ready", 64'(req_ready), 64'(0));
    end
    rdy = 1; req_valid = '0;
    cycle();
    chk("frz_r1", 64'(register_commit_value), 64'(201));
    cycle();
    chk("frz_r2", 64'(register_commit_value), 64'(202));
    cycle();
    chk("frz_done", 64'(register_update_flag), 64'(0));

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, 4'($urandom));
      rdy   = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    rdy = 1; flush = 0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
